// File: rtl/fifo_pkg.sv
// Shared constants and types for the 4-deep FIFO control slice.
package fifo_pkg;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
  localparam int CNT_W = 4;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. With both requests eligible, the
// requester that did not win the previous grant wins this one.
module rr_arb2
  import fifo_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt
);

  logic       last_gnt_reg;
  logic       last_gnt_next;
  logic [1:0] elig;

  // A request is eligible only with space available and reset released.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_elig
      assign elig[gi] = req[gi] & enable & reset;
    end
  endgenerate

  // Grant decode; last_gnt follows the winner only when a grant is issued.
  always_comb begin
    gnt           = 2'b00;
    last_gnt_next = last_gnt_reg;
    case (elig)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_gnt_reg ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    if (|gnt) begin
      last_gnt_next = gnt[1];
    end
  end

  // Round-robin history; reset value 1 lets producer 0 win first contention.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_gnt_reg <= 1'b1;
    end else begin
      last_gnt_reg <= last_gnt_next;
    end
  end

endmodule

// File: rtl/fifo_arb_ctrl.sv
// Control block for a 4-deep FIFO: shares the write port between two
// producers, sequences storage pointers, tracks occupancy and flags.
module fifo_arb_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH = fifo_pkg::DEPTH,
  parameter int PTR_W = fifo_pkg::PTR_W,
  parameter int CNT_W = fifo_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             wr_en,
  output logic             wr_sel,
  output logic [PTR_W-1:0] wr_addr,
  input  logic             rd_req,
  output logic             rd_en,
  output logic [PTR_W-1:0] rd_addr,
  output logic             rd_valid,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             udf_err,
  input  logic             err_clr
);

  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             rd_valid_reg;
  logic             udf_err_reg, udf_err_next;
  logic [1:0]       gnt;

  // Flags come from the registered count, so a pop never frees space
  // in its own cycle and a push never enables a pop in its own cycle.
  assign full  = (count_reg == CNT_FULL);
  assign empty = (count_reg == '0);

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({req1, req0}),
    .enable (~full),
    .gnt    (gnt)
  );

  assign gnt0     = gnt[0];
  assign gnt1     = gnt[1];
  assign wr_en    = gnt[0] | gnt[1];
  assign wr_sel   = gnt[1];
  assign rd_en    = rd_req & ~empty & reset;
  assign wr_addr  = wr_ptr_reg;
  assign rd_addr  = rd_ptr_reg;
  assign count    = count_reg;
  assign rd_valid = rd_valid_reg;
  assign udf_err  = udf_err_reg;

  // Next-state for pointers, occupancy and the sticky underflow flag.
  always_comb begin
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    count_next   = count_reg;
    udf_err_next = udf_err_reg;
    if (wr_en) begin
      wr_ptr_next = wr_ptr_reg + PTR_ONE;
    end
    if (rd_en) begin
      rd_ptr_next = rd_ptr_reg + PTR_ONE;
    end
    case ({wr_en, rd_en})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
    // Set has priority over clear when both happen together.
    if (rd_req && empty) begin
      udf_err_next = 1'b1;
    end else if (err_clr) begin
      udf_err_next = 1'b0;
    end
  end

  // State registers; reset discards everything offered in that cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      rd_valid_reg <= 1'b0;
      udf_err_reg  <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      rd_valid_reg <= rd_en;
      udf_err_reg  <= udf_err_next;
    end
  end

endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// Directed testbench for fifo_arb_ctrl with hand-computed expectations.
module tb_fifo_arb_ctrl;

  logic       clk;
  logic       reset;
  logic       req0, req1, rd_req, err_clr;
  logic       gnt0, gnt1, wr_en, wr_sel, rd_en, rd_valid;
  logic       full, empty, udf_err;
  logic [1:0] wr_addr, rd_addr;
  logic [3:0] count;

  int errors = 0;
  int checks = 0;

  fifo_arb_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .req0     (req0),
    .req1     (req1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_addr  (wr_addr),
    .rd_req   (rd_req),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_valid (rd_valid),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .udf_err  (udf_err),
    .err_clr  (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and return to the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    $display("t=%0t req=%b%b gnt=%b%b rd_req=%b rd_en=%b wa=%0d ra=%0d cnt=%0d udf=%b",
             $time, req1, req0, gnt1, gnt0, rd_req, rd_en, wr_addr, rd_addr, count, udf_err);
  endtask

  task automatic idle();
    req0 = 0; req1 = 0; rd_req = 0; err_clr = 0;
  endtask

  task automatic test_reset();
    reset = 0; req0 = 1; req1 = 1; rd_req = 1; err_clr = 0;
    cyc(); cyc();
    #1;
    checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL rst_gnt0: got %b expected 0", gnt0); end
    checks++; if (gnt1 !== 1'b0) begin errors++; $display("FAIL rst_gnt1: got %b expected 0", gnt1); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b expected 0", wr_en); end
    checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en: got %b expected 0", rd_en); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b expected 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b expected 0", full); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid: got %b expected 0", rd_valid); end
    checks++; if (udf_err !== 1'b0) begin errors++; $display("FAIL rst_udf: got %b expected 0", udf_err); end
    checks++; if (wr_addr !== 2'd0) begin errors++; $display("FAIL rst_wr_addr: got %0d expected 0", wr_addr); end
    checks++; if (rd_addr !== 2'd0) begin errors++; $display("FAIL rst_rd_addr: got %0d expected 0", rd_addr); end
    reset = 1; idle();
    cyc();
    #1;
    checks++; if ((gnt0 | gnt1) !== 1'b0) begin errors++; $display("FAIL idle_gnt: got %b%b expected 00", gnt1, gnt0); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL idle_count: got %0d expected 0", count); end
    checks++; if (udf_err !== 1'b0) begin errors++; $display("FAIL idle_udf: got %b expected 0", udf_err); end
  endtask

  // Both producers held from empty: alternating grants until full.
  task automatic test_fill();
    logic exp_g0;
    logic [1:0] exp_a;
    for (int i = 0; i < 4; i++) begin
      req0 = 1; req1 = 1;
      #1;
      exp_g0 = (i % 2 == 0);
      exp_a = 2'(i);
      checks++; if (gnt0 !== exp_g0) begin errors++; $display("FAIL fill_gnt0[%0d]: got %b expected %b", i, gnt0, exp_g0); end
      checks++; if (gnt1 !== ~exp_g0) begin errors++; $display("FAIL fill_gnt1[%0d]: got %b expected %b", i, gnt1, ~exp_g0); end
      checks++; if (wr_sel !== ~exp_g0) begin errors++; $display("FAIL fill_wr_sel[%0d]: got %b expected %b", i, wr_sel, ~exp_g0); end
      checks++; if (wr_addr !== exp_a) begin errors++; $display("FAIL fill_wr_addr[%0d]: got %0d expected %0d", i, wr_addr, exp_a); end
      checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL fill_wr_en[%0d]: got %b expected 1", i, wr_en); end
      cyc();
    end
    #1;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b expected 1", full); end
    checks++; if (count !== 4'd4) begin errors++; $display("FAIL fill_count: got %0d expected 4", count); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty: got %b expected 0", empty); end
    checks++; if ((gnt0 | gnt1 | wr_en) !== 1'b0) begin errors++; $display("FAIL fill_blocked: got gnt=%b%b wr_en=%b expected 0", gnt1, gnt0, wr_en); end
  endtask

  // Drain from full; the first pop coincides with a blocked write.
  task automatic test_drain();
    logic [1:0] exp_a;
    logic [3:0] exp_c;
    for (int i = 0; i < 4; i++) begin
      req0 = (i == 0); req1 = 0; rd_req = 1;
      #1;
      exp_a = 2'(i);
      exp_c = 4'(4 - i);
      checks++; if (rd_en !== 1'b1) begin errors++; $display("FAIL drain_rd_en[%0d]: got %b expected 1", i, rd_en); end
      checks++; if (rd_addr !== exp_a) begin errors++; $display("FAIL drain_rd_addr[%0d]: got %0d expected %0d", i, rd_addr, exp_a); end
      checks++; if (rd_valid !== (i != 0)) begin errors++; $display("FAIL drain_rd_valid[%0d]: got %b expected %b", i, rd_valid, (i != 0)); end
      checks++; if (count !== exp_c) begin errors++; $display("FAIL drain_count[%0d]: got %0d expected %0d", i, count, exp_c); end
      checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL drain_gnt0[%0d]: got %b expected 0", i, gnt0); end
      cyc();
    end
    idle();
    #1;
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL drain_last_valid: got %b expected 1", rd_valid); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL drain_count_end: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", empty); end
    cyc();
    #1;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL drain_valid_off: got %b expected 0", rd_valid); end
  endtask

  // Simultaneous push and pop at count=2; both pointers wrap.
  task automatic test_back_to_back();
    logic [1:0] exp_w, exp_r;
    for (int i = 0; i < 2; i++) begin
      req0 = 1;
      #1;
      exp_w = 2'(i);
      checks++; if (wr_addr !== exp_w) begin errors++; $display("FAIL b2b_pre_wa[%0d]: got %0d expected %0d", i, wr_addr, exp_w); end
      cyc();
    end
    for (int i = 0; i < 6; i++) begin
      req0 = 1; rd_req = 1;
      #1;
      exp_w = 2'((2 + i) % 4);
      exp_r = 2'(i % 4);
      checks++; if (count !== 4'd2) begin errors++; $display("FAIL b2b_count[%0d]: got %0d expected 2", i, count); end
      checks++; if (wr_addr !== exp_w) begin errors++; $display("FAIL b2b_wr_addr[%0d]: got %0d expected %0d", i, wr_addr, exp_w); end
      checks++; if (rd_addr !== exp_r) begin errors++; $display("FAIL b2b_rd_addr[%0d]: got %0d expected %0d", i, rd_addr, exp_r); end
      checks++; if ((gnt0 & rd_en) !== 1'b1) begin errors++; $display("FAIL b2b_strobes[%0d]: got gnt0=%b rd_en=%b expected 1 1", i, gnt0, rd_en); end
      cyc();
    end
    idle();
    #1;
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL b2b_count_end: got %0d expected 2", count); end
    checks++; if (wr_addr !== 2'd0) begin errors++; $display("FAIL b2b_wa_end: got %0d expected 0", wr_addr); end
    checks++; if (rd_addr !== 2'd2) begin errors++; $display("FAIL b2b_ra_end: got %0d expected 2", rd_addr); end
    for (int i = 0; i < 2; i++) begin
      rd_req = 1;
      cyc();
    end
    idle();
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b expected 1", empty); end
    checks++; if (rd_addr !== 2'd0) begin errors++; $display("FAIL b2b_ra_wrap: got %0d expected 0", rd_addr); end
  endtask

  // Pop while empty with a concurrent push; sticky flag and clear priority.
  task automatic test_underflow();
    rd_req = 1; req1 = 1;
    #1;
    checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL udf_rd_en: got %b expected 0", rd_en); end
    checks++; if (gnt1 !== 1'b1) begin errors++; $display("FAIL udf_gnt1: got %b expected 1", gnt1); end
    checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL udf_gnt0: got %b expected 0", gnt0); end
    checks++; if (wr_sel !== 1'b1) begin errors++; $display("FAIL udf_wr_sel: got %b expected 1", wr_sel); end
    cyc();
    idle();
    #1;
    checks++; if (udf_err !== 1'b1) begin errors++; $display("FAIL udf_set: got %b expected 1", udf_err); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL udf_count: got %0d expected 1", count); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL udf_rd_valid: got %b expected 0", rd_valid); end
    err_clr = 1;
    cyc();
    err_clr = 0;
    #1;
    checks++; if (udf_err !== 1'b0) begin errors++; $display("FAIL udf_clear: got %b expected 0", udf_err); end
    rd_req = 1;
    #1;
    checks++; if (rd_en !== 1'b1) begin errors++; $display("FAIL udf_pop: got %b expected 1", rd_en); end
    cyc();
    rd_req = 1; err_clr = 1;
    cyc();
    idle();
    #1;
    checks++; if (udf_err !== 1'b1) begin errors++; $display("FAIL udf_set_wins: got %b expected 1", udf_err); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL udf_no_valid: got %b expected 0", rd_valid); end
    err_clr = 1;
    cyc();
    err_clr = 0;
    #1;
    checks++; if (udf_err !== 1'b0) begin errors++; $display("FAIL udf_clear2: got %b expected 0", udf_err); end
  endtask

  // Reset in the middle of traffic discards state and the pending write.
  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) begin
      req0 = 1;
      cyc();
    end
    idle();
    #1;
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL mrst_pre_count: got %0d expected 3", count); end
    checks++; if (wr_addr !== 2'd0) begin errors++; $display("FAIL mrst_pre_wa: got %0d expected 0", wr_addr); end
    checks++; if (rd_addr !== 2'd1) begin errors++; $display("FAIL mrst_pre_ra: got %0d expected 1", rd_addr); end
    reset = 0; req0 = 1; req1 = 1; rd_req = 1;
    #1;
    checks++; if ((gnt0 | gnt1 | wr_en | rd_en) !== 1'b0) begin errors++; $display("FAIL mrst_comb: got gnt=%b%b wr_en=%b rd_en=%b expected 0", gnt1, gnt0, wr_en, rd_en); end
    cyc();
    reset = 1; rd_req = 0;
    #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL mrst_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mrst_empty: got %b expected 1", empty); end
    checks++; if ((wr_addr | rd_addr) !== 2'd0) begin errors++; $display("FAIL mrst_ptrs: got wa=%0d ra=%0d expected 0 0", wr_addr, rd_addr); end
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL mrst_last_gnt: got gnt0=%b expected 1", gnt0); end
    checks++; if (gnt1 !== 1'b0) begin errors++; $display("FAIL mrst_gnt1: got %b expected 0", gnt1); end
    cyc();
    idle();
    #1;
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL mrst_after: got %0d expected 1", count); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_underflow();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
